// File: rtl/axi_read_error_resp_gen.sv
// axi_read_error_resp_gen
// Companion stage to the AR address decoder of one AXI slave port. It tracks
// the number of legal reads still in flight and, after a decode error, answers
// the faulting read with an arlen+1 beat DECERR burst once every earlier read
// has completed. The last accepted beat grants the decoder so it can leave its
// ERROR state.
//
// R handshake: a beat transfers in any cycle where err_rvalid_o && err_rready_i
// are both high. Once err_rvalid_o is high, it and the whole payload
// (rid/rdata/rresp/rlast/ruser) stay stable until that transfer happens.
// err_rvalid_o never depends combinationally on err_rready_i.
//
// Debug outputs expose the FSM state (0=IDLE, 1=DRAIN, 2=SEND) and the
// outstanding-read count so checkers can bind to them directly.

module axi_read_error_resp_gen #(
  parameter int AXI_ID_IN       = 4,
  parameter int AXI_DATA_W      = 64,
  parameter int AXI_USER_W      = 6,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // outstanding-read bookkeeping
  input  logic                  incr_req_i,
  input  logic                  trans_done_i,
  output logic                  full_counter_o,
  output logic                  outstanding_trans_o,
  // faulting AR capture
  input  logic                  sample_ardata_info_i,
  input  logic [AXI_ID_IN-1:0]  arid_i,
  input  logic [7:0]            arlen_i,
  input  logic [AXI_USER_W-1:0] aruser_i,
  // grant back to the decoder
  output logic                  error_gnt_o,
  // error R channel
  output logic                  err_rvalid_o,
  input  logic                  err_rready_i,
  output logic [AXI_ID_IN-1:0]  err_rid_o,
  output logic [AXI_DATA_W-1:0] err_rdata_o,
  output logic [1:0]            err_rresp_o,
  output logic                  err_rlast_o,
  output logic [AXI_USER_W-1:0] err_ruser_o,
  // debug visibility
  output logic [1:0]            dbg_state_o,
  output logic [CNT_W-1:0]      dbg_count_o
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       RESP_DEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              beat_q, beat_d;
  logic [AXI_ID_IN-1:0]    id_q, id_d;
  logic [AXI_USER_W-1:0]   user_q, user_d;

  logic                    cnt_full;
  logic                    cnt_zero;
  logic                    last_beat;
  logic                    beat_hs;

  assign cnt_full  = (count_q == MAX_CNT);
  assign cnt_zero  = (count_q == '0);
  assign last_beat = (beat_q == 8'd0);
  assign beat_hs   = (state_q == ST_SEND) && err_rready_i;

  // ---------------------------------------------------------------------------
  // Outstanding-read counter: runs every cycle regardless of the FSM. An incr
  // while full or a done while empty is a protocol error upstream; the counter
  // simply holds instead of wrapping.
  always_comb begin
    count_d = count_q;
    unique case ({incr_req_i, trans_done_i})
      2'b10:   if (!cnt_full) count_d = count_q + CNT_ONE;
      2'b01:   if (!cnt_zero) count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign full_counter_o      = cnt_full;
  assign outstanding_trans_o = !cnt_zero;

  // ---------------------------------------------------------------------------
  // FSM state and burst context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      id_q    <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
      user_q  <= user_d;
    end
  end

  // Next-state logic. The capture strobe only matters in IDLE: while the
  // decoder sits in ERROR it stalls AR, so a strobe elsewhere is ignored.
  // DRAIN looks at the registered count so the burst starts the first cycle
  // after the last earlier read has retired.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    id_d    = id_q;
    user_d  = user_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_ardata_info_i) begin
          state_d = ST_DRAIN;
          beat_d  = arlen_i;
          id_d    = arid_i;
          user_d  = aruser_i;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (beat_hs) begin
          if (last_beat) state_d = ST_IDLE;
          else           beat_d  = beat_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Grant is combinational on the final accepted beat only.
  always_comb begin
    err_rvalid_o = 1'b0;
    err_rlast_o  = 1'b0;
    error_gnt_o  = 1'b0;
    if (state_q == ST_SEND) begin
      err_rvalid_o = 1'b1;
      err_rlast_o  = last_beat;
      error_gnt_o  = beat_hs && last_beat;
    end
  end

  assign err_rid_o   = id_q;
  assign err_ruser_o = user_q;
  assign err_rdata_o = '0;
  assign err_rresp_o = RESP_DEC;

  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_axi_read_error_resp_gen.sv
// Directed bench for axi_read_error_resp_gen: counter behaviour, DECERR burst
// generation with and without backpressure, drain waiting and reset abort.

module tb_axi_read_error_resp_gen;

  localparam int AXI_ID_IN       = 4;
  localparam int AXI_DATA_W      = 64;
  localparam int AXI_USER_W      = 6;
  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_W           = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  logic                  clk;
  logic                  rst_n;
  logic                  incr_req_i;
  logic                  trans_done_i;
  logic                  full_counter_o;
  logic                  outstanding_trans_o;
  logic                  sample_ardata_info_i;
  logic [AXI_ID_IN-1:0]  arid_i;
  logic [7:0]            arlen_i;
  logic [AXI_USER_W-1:0] aruser_i;
  logic                  error_gnt_o;
  logic                  err_rvalid_o;
  logic                  err_rready_i;
  logic [AXI_ID_IN-1:0]  err_rid_o;
  logic [AXI_DATA_W-1:0] err_rdata_o;
  logic [1:0]            err_rresp_o;
  logic                  err_rlast_o;
  logic [AXI_USER_W-1:0] err_ruser_o;
  logic [1:0]            dbg_state_o;
  logic [CNT_W-1:0]      dbg_count_o;

  int n_checks;
  int n_fail;
  int exp_cnt;
  int hs_cnt;
  int gnt_cnt;

  axi_read_error_resp_gen #(
    .AXI_ID_IN      (AXI_ID_IN),
    .AXI_DATA_W     (AXI_DATA_W),
    .AXI_USER_W     (AXI_USER_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .incr_req_i          (incr_req_i),
    .trans_done_i        (trans_done_i),
    .full_counter_o      (full_counter_o),
    .outstanding_trans_o (outstanding_trans_o),
    .sample_ardata_info_i(sample_ardata_info_i),
    .arid_i              (arid_i),
    .arlen_i             (arlen_i),
    .aruser_i            (aruser_i),
    .error_gnt_o         (error_gnt_o),
    .err_rvalid_o        (err_rvalid_o),
    .err_rready_i        (err_rready_i),
    .err_rid_o           (err_rid_o),
    .err_rdata_o         (err_rdata_o),
    .err_rresp_o         (err_rresp_o),
    .err_rlast_o         (err_rlast_o),
    .err_ruser_o         (err_ruser_o),
    .dbg_state_o         (dbg_state_o),
    .dbg_count_o         (dbg_count_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking task
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change at posedge+1, outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Legal-read AR handshake; flags an upstream protocol violation when full.
  task automatic pulse_incr(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_cnt == MAX_OUTSTANDING)
        $display("note: incr while full (protocol violation), counter must hold");
      else
        exp_cnt++;
      incr_req_i = 1'b1;
      step();
    end
    incr_req_i = 1'b0;
  endtask

  task automatic pulse_done(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_cnt == 0)
        $display("note: done while empty (protocol violation), counter must hold");
      else
        exp_cnt--;
      trans_done_i = 1'b1;
      step();
    end
    trans_done_i = 1'b0;
  endtask

  // Capture strobe for one cycle, then scramble the AR inputs.
  task automatic sample_ar(input logic [3:0] id, input logic [7:0] len, input logic [5:0] user);
    sample_ardata_info_i = 1'b1;
    arid_i   = id;
    arlen_i  = len;
    aruser_i = user;
    step();
    sample_ardata_info_i = 1'b0;
    arid_i   = '0;
    arlen_i  = 8'hFF;
    aruser_i = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    hs_cnt   = 0;
    gnt_cnt  = 0;

    rst_n                = 1'b0;
    incr_req_i           = 1'b0;
    trans_done_i         = 1'b0;
    sample_ardata_info_i = 1'b0;
    arid_i               = '0;
    arlen_i              = '0;
    aruser_i             = '0;
    err_rready_i         = 1'b0;

    // Reset state
    repeat (3) step();
    settle();
    check("rst_count",   64'(dbg_count_o), 64'd0);
    check("rst_outst",   64'(outstanding_trans_o), 64'd0);
    check("rst_full",    64'(full_counter_o), 64'd0);
    check("rst_rvalid",  64'(err_rvalid_o), 64'd0);
    check("rst_rlast",   64'(err_rlast_o), 64'd0);
    check("rst_gnt",     64'(error_gnt_o), 64'd0);
    check("rst_state",   64'(dbg_state_o), 64'(S_IDLE));
    check("rst_rid",     64'(err_rid_o), 64'd0);
    check("rst_ruser",   64'(err_ruser_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Counter: 3 incr, then incr+done together
    pulse_incr(3);
    incr_req_i = 1'b1;
    trans_done_i = 1'b1;
    step();
    incr_req_i = 1'b0;
    trans_done_i = 1'b0;
    settle();
    check("cnt_3",       64'(dbg_count_o), 64'd3);
    check("cnt_3_outst", 64'(outstanding_trans_o), 64'd1);
    check("cnt_3_full",  64'(full_counter_o), 64'd0);
    pulse_done(3);
    settle();
    check("cnt_back_0",  64'(dbg_count_o), 64'd0);

    // Counter saturation and floor
    pulse_incr(7);
    settle();
    check("cnt_7_full",  64'(full_counter_o), 64'd0);
    pulse_incr(2);
    settle();
    check("cnt_sat",     64'(dbg_count_o), 64'd8);
    check("cnt_sat_full",64'(full_counter_o), 64'd1);
    check("cnt_sat_out", 64'(outstanding_trans_o), 64'd1);
    pulse_done(8);
    settle();
    check("cnt_drain",   64'(dbg_count_o), 64'd0);
    check("cnt_drain_o", 64'(outstanding_trans_o), 64'd0);
    check("cnt_drain_f", 64'(full_counter_o), 64'd0);
    pulse_done(1);
    settle();
    check("cnt_floor",   64'(dbg_count_o), 64'd0);

    // Burst arlen=3, id=5, rready held high, count already 0
    err_rready_i = 1'b1;
    settle();
    check("b4_idle_valid", 64'(err_rvalid_o), 64'd0);
    sample_ar(4'd5, 8'd3, 6'h2A);
    settle();
    check("b4_drain_st",   64'(dbg_state_o), 64'(S_DRAIN));
    check("b4_drain_vld",  64'(err_rvalid_o), 64'd0);
    check("b4_drain_gnt",  64'(error_gnt_o), 64'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      settle();
      check("b4_rvalid", 64'(err_rvalid_o), 64'd1);
      check("b4_rid",    64'(err_rid_o), 64'd5);
      check("b4_rresp",  64'(err_rresp_o), 64'd3);
      check("b4_rdata",  err_rdata_o, 64'd0);
      check("b4_ruser",  64'(err_ruser_o), 64'h2A);
      check("b4_rlast",  64'(err_rlast_o), (b == 3) ? 64'd1 : 64'd0);
      check("b4_gnt",    64'(error_gnt_o), (b == 3) ? 64'd1 : 64'd0);
      step();
    end
    settle();
    check("b4_after_vld", 64'(err_rvalid_o), 64'd0);
    check("b4_after_st",  64'(dbg_state_o), 64'(S_IDLE));
    check("b4_after_gnt", 64'(error_gnt_o), 64'd0);

    // Drain wait: count=2, arlen=0
    pulse_incr(2);
    sample_ar(4'd3, 8'd0, 6'h11);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dr_wait_vld", 64'(err_rvalid_o), 64'd0);
      check("dr_wait_st",  64'(dbg_state_o), 64'(S_DRAIN));
      step();
    end
    // a strobe while not IDLE must not recapture
    sample_ar(4'd9, 8'd5, 6'h3F);
    trans_done_i = 1'b1;
    exp_cnt--;
    settle();
    check("dr_done1_vld", 64'(err_rvalid_o), 64'd0);
    step();
    exp_cnt--;
    settle();
    check("dr_done2_vld", 64'(err_rvalid_o), 64'd0);
    step();
    trans_done_i = 1'b0;
    settle();
    check("dr_cnt0",      64'(dbg_count_o), 64'd0);
    check("dr_last_drain",64'(err_rvalid_o), 64'd0);
    step();
    settle();
    check("dr_vld",   64'(err_rvalid_o), 64'd1);
    check("dr_rlast", 64'(err_rlast_o), 64'd1);
    check("dr_gnt",   64'(error_gnt_o), 64'd1);
    check("dr_rid",   64'(err_rid_o), 64'd3);
    check("dr_ruser", 64'(err_ruser_o), 64'h11);
    step();
    settle();
    check("dr_after_vld", 64'(err_rvalid_o), 64'd0);
    check("dr_after_st",  64'(dbg_state_o), 64'(S_IDLE));

    // Backpressure: arlen=1, rready 0,1,0,1
    err_rready_i = 1'b0;
    sample_ar(4'd9, 8'd1, 6'h15);
    step();
    hs_cnt  = 0;
    gnt_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      err_rready_i = (c % 2 == 1);
      settle();
      if (err_rvalid_o && err_rready_i) hs_cnt++;
      if (error_gnt_o) gnt_cnt++;
      check("bp_vld",   64'(err_rvalid_o), 64'd1);
      check("bp_rid",   64'(err_rid_o), 64'd9);
      check("bp_ruser", 64'(err_ruser_o), 64'h15);
      check("bp_rlast", 64'(err_rlast_o), (c >= 2) ? 64'd1 : 64'd0);
      check("bp_gnt",   64'(error_gnt_o), (c == 3) ? 64'd1 : 64'd0);
      step();
    end
    err_rready_i = 1'b0;
    settle();
    check("bp_hs_cnt",   64'(hs_cnt), 64'd2);
    check("bp_gnt_cnt",  64'(gnt_cnt), 64'd1);
    check("bp_after_vld",64'(err_rvalid_o), 64'd0);

    // Reset during SEND
    err_rready_i = 1'b0;
    sample_ar(4'd7, 8'd7, 6'h01);
    step();
    pulse_incr(2);
    settle();
    check("ra_pre_vld", 64'(err_rvalid_o), 64'd1);
    check("ra_pre_cnt", 64'(dbg_count_o), 64'd2);
    err_rready_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("ra_vld",   64'(err_rvalid_o), 64'd0);
    check("ra_st",    64'(dbg_state_o), 64'(S_IDLE));
    check("ra_gnt",   64'(error_gnt_o), 64'd0);
    check("ra_cnt",   64'(dbg_count_o), 64'd0);
    check("ra_outst", 64'(outstanding_trans_o), 64'd0);
    check("ra_rlast", 64'(err_rlast_o), 64'd0);
    exp_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    settle();
    check("ra_post_vld", 64'(err_rvalid_o), 64'd0);
    check("ra_post_gnt", 64'(error_gnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
